// File: rtl/hazard_pkg.sv
// Shared types and encodings for the 5-stage pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [0:0] {RUN, MUL_BUSY} state_e;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_JMP = 2'b01;
  localparam logic [1:0] PC_SEL_BR  = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Entries hold rd zero-extended to this width; REG_AW must not exceed it.
  localparam int unsigned REG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_MAX-1:0] rd;
    logic                  we;
    logic                  is_load;
  } sb_entry_t;

  function automatic logic sb_match(sb_entry_t e, logic [REG_AW_MAX-1:0] s);
    return e.valid && e.we && (s != '0) && (e.rd == s);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// EX/MEM/WB occupancy shadow plus RAW comparators for both ID source operands.
import hazard_pkg::*;

module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  sb_entry_t         id_entry,
  input  logic              ex_hold,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rt,
  output logic [2:0]        hit_a,
  output logic [2:0]        hit_b,
  output logic              ex_is_load
);

  sb_entry_t ex_q, mem_q, wb_q;
  logic [REG_AW_MAX-1:0] sa, sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (ex_hold) begin
      // EX keeps the multi-cycle op; an empty slot drains into MEM.
      mem_q <= '0;
      wb_q  <= mem_q;
    end else begin
      ex_q  <= id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_comb begin
    sa = REG_AW_MAX'(rs);
    sb = REG_AW_MAX'(rt);
    hit_a = {sb_match(wb_q, sa), sb_match(mem_q, sa), sb_match(ex_q, sa)};
    hit_b = {sb_match(wb_q, sb), sb_match(mem_q, sb), sb_match(ex_q, sb)} & {3{uses_rt}};
    ex_is_load = ex_q.is_load;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush/PC-select sequencer for the 5-stage MIPS pipeline.
// Define HAZARD_FWD_EN to enable EX operand forwarding (load-use stall only).
import hazard_pkg::*;

module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we_reg,
  input  logic              id_is_load,
  input  logic              id_is_mul,
  input  logic              id_jmp,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              ex_hold,
  output logic              bubble,
  output logic              flush_ifid,
  output logic [1:0]        pc_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam int unsigned CntW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  sb_entry_t       id_entry;
  logic [2:0]      hit_a, hit_b;
  logic            ex_is_load, raw, unused;
  logic            stall_c, ex_hold_c, bubble_c, flush_c;
  logic [1:0]      pc_sel_c;

  hazard_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_entry   (id_entry),
    .ex_hold    (ex_hold_c),
    .rs         (id_rs),
    .rt         (id_rt),
    .uses_rt    (id_uses_rt),
    .hit_a      (hit_a),
    .hit_b      (hit_b),
    .ex_is_load (ex_is_load)
  );

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

  assign raw    = ex_is_load && (hit_a[0] || hit_b[0]);
  assign unused = hit_a[2] ^ hit_b[2];

  // The producer now in EX/MEM will sit in MEM/WB once this op reaches EX.
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (id_entry.valid) begin
      if (hit_a[0])      fwd_a_d = FWD_MEM;
      else if (hit_a[1]) fwd_a_d = FWD_WB;
      if (hit_b[0])      fwd_b_d = FWD_MEM;
      else if (hit_b[1]) fwd_b_d = FWD_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!ex_hold_c) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a = fwd_a_q & {2{rst_n}};
  assign fwd_b = fwd_b_q & {2{rst_n}};
`else
  assign raw    = |{hit_a, hit_b};
  assign unused = ex_is_load;
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  always_comb begin
    stall_c   = 1'b0;
    ex_hold_c = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    pc_sel_c  = PC_SEL_SEQ;
    state_d   = state_q;
    cnt_d     = cnt_q;

    if (ex_branch_taken) begin
      flush_c  = 1'b1;
      bubble_c = 1'b1;
      pc_sel_c = PC_SEL_BR;
    end else if (state_q == MUL_BUSY) begin
      stall_c   = 1'b1;
      ex_hold_c = 1'b1;
    end else if (raw) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
    end else if (id_jmp && id_valid) begin
      flush_c  = 1'b1;
      pc_sel_c = PC_SEL_JMP;
    end

    id_entry         = '0;
    id_entry.valid   = id_valid && !bubble_c;
    id_entry.rd      = REG_AW_MAX'(id_rd);
    id_entry.we      = id_we_reg;
    id_entry.is_load = id_is_load;

    unique case (state_q)
      RUN: begin
        if (id_entry.valid && id_is_mul && (MUL_LATENCY > 1) && !ex_hold_c) begin
          state_d = MUL_BUSY;
          cnt_d   = CntW'(MUL_LATENCY - 1);
        end
      end
      MUL_BUSY: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall      = stall_c & rst_n;
  assign ex_hold    = ex_hold_c & rst_n;
  assign bubble     = bubble_c & rst_n;
  assign flush_ifid = flush_c & rst_n;
  assign pc_sel     = pc_sel_c & {2{rst_n}};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (either HAZARD_FWD_EN build).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rt, id_we_reg, id_is_load, id_is_mul, id_jmp;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_branch_taken;
  logic       stall, ex_hold, bubble, flush_ifid;
  logic [1:0] pc_sel, fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_AW      (5),
    .MUL_LATENCY (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_rd           (id_rd),
    .id_we_reg       (id_we_reg),
    .id_is_load      (id_is_load),
    .id_is_mul       (id_is_mul),
    .id_jmp          (id_jmp),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .ex_hold         (ex_hold),
    .bubble          (bubble),
    .flush_ifid      (flush_ifid),
    .pc_sel          (pc_sel),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rd, input logic we,
                       input logic ld, input logic mul, input logic jmp);
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_uses_rt = urt;
    id_rd      = rd;
    id_we_reg  = we;
    id_is_load = ld;
    id_is_mul  = mul;
    id_jmp     = jmp;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) step();
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".stall"}, 8'(stall), 8'd0);
    chk({tag, ".ex_hold"}, 8'(ex_hold), 8'd0);
    chk({tag, ".bubble"}, 8'(bubble), 8'd0);
    chk({tag, ".flush"}, 8'(flush_ifid), 8'd0);
    chk({tag, ".pc_sel"}, 8'(pc_sel), 8'd0);
    chk({tag, ".fwd_a"}, 8'(fwd_a), 8'd0);
    chk({tag, ".fwd_b"}, 8'(fwd_b), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ex_branch_taken = 1'b0;
    idle();
    #12;
    chk_all0("reset");
    rst_n = 1'b1;
    step();

    // ADD r3=r1+r2 ; SUB r4=r3-r1
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0);
    #2 chk("addsub.add_stall", 8'(stall), 8'd0);
    step();
    drive(1, 3, 1, 1, 4, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    #2 chk("addsub.stall", 8'(stall), 8'd0);
    step();
    idle();
    #2 chk("addsub.fwd_a", 8'(fwd_a), 8'd1);
    chk("addsub.fwd_b", 8'(fwd_b), 8'd0);
`else
    for (int i = 0; i < 3; i++) begin
      #2 chk("addsub.stall", 8'(stall), 8'd1);
      chk("addsub.bubble", 8'(bubble), 8'd1);
      step();
    end
    #2 chk("addsub.issue", 8'(stall), 8'd0);
    step();
    idle();
    #2 chk("addsub.fwd_a", 8'(fwd_a), 8'd0);
`endif
    drain();

    // ADD r3 ; unrelated ADD r9 ; SUB r4=r3-r1
    drive(1, 1, 2, 1, 3, 1, 0, 0, 0);
    step();
    drive(1, 1, 2, 1, 9, 1, 0, 0, 0);
    step();
    drive(1, 3, 1, 1, 4, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    #2 chk("gap.stall", 8'(stall), 8'd0);
    step();
    idle();
    #2 chk("gap.fwd_a", 8'(fwd_a), 8'd2);
`else
    for (int i = 0; i < 2; i++) begin
      #2 chk("gap.stall", 8'(stall), 8'd1);
      step();
    end
    #2 chk("gap.issue", 8'(stall), 8'd0);
`endif
    drain();

    // LW r5,0(r1) ; ADD r6=r5+r2
    drive(1, 1, 0, 0, 5, 1, 1, 0, 0);
    step();
    drive(1, 5, 2, 1, 6, 1, 0, 0, 0);
`ifdef HAZARD_FWD_EN
    #2 chk("lu.stall", 8'(stall), 8'd1);
    chk("lu.bubble", 8'(bubble), 8'd1);
    step();
    #2 chk("lu.issue", 8'(stall), 8'd0);
    step();
    idle();
    #2 chk("lu.fwd_a", 8'(fwd_a), 8'd2);
    chk("lu.fwd_b", 8'(fwd_b), 8'd0);
`else
    for (int i = 0; i < 3; i++) begin
      #2 chk("lu.stall", 8'(stall), 8'd1);
      step();
    end
    #2 chk("lu.issue", 8'(stall), 8'd0);
`endif
    drain();

    // MUL r7=r1*r2 followed by a reader of r7 once EX frees up
    drive(1, 1, 2, 1, 7, 1, 0, 1, 0);
    #2 chk("mul.enter_stall", 8'(stall), 8'd0);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      #2 chk("mul.stall", 8'(stall), 8'd1);
      chk("mul.ex_hold", 8'(ex_hold), 8'd1);
      chk("mul.bubble", 8'(bubble), 8'd0);
      step();
    end
    drive(1, 7, 0, 1, 8, 1, 0, 0, 0);
    #2 chk("mul.run_hold", 8'(ex_hold), 8'd0);
`ifdef HAZARD_FWD_EN
    chk("mul.rd_stall", 8'(stall), 8'd0);
    step();
    idle();
    #2 chk("mul.fwd_a", 8'(fwd_a), 8'd1);
`else
    // MUL still in EX, then MEM, then WB
    for (int i = 0; i < 3; i++) begin
      if (i > 0) #2;
      chk("mul.rd_stall", 8'(stall), 8'd1);
      step();
    end
    #2 chk("mul.rd_issue", 8'(stall), 8'd0);
`endif
    drain();

    // Reset asserted in the second MUL_BUSY cycle
    drive(1, 1, 2, 1, 7, 1, 0, 1, 0);
    step();
    idle();
    #2 chk("mrst.busy1", 8'(ex_hold), 8'd1);
    step();
    #2 chk("mrst.busy2", 8'(ex_hold), 8'd1);
    rst_n = 1'b0;
    #1 chk_all0("mrst.in_reset");
    step();
    rst_n = 1'b1;
    #2 chk("mrst.after_stall", 8'(stall), 8'd0);
    chk("mrst.after_hold", 8'(ex_hold), 8'd0);
    step();
    #2 chk("mrst.stays_run", 8'(stall), 8'd0);
    drain();

    // Branch taken while ID has a load-use hazard
    drive(1, 1, 0, 0, 5, 1, 1, 0, 0);
    step();
    drive(1, 5, 2, 1, 6, 1, 0, 0, 0);
    ex_branch_taken = 1'b1;
    #2 chk("br.flush", 8'(flush_ifid), 8'd1);
    chk("br.bubble", 8'(bubble), 8'd1);
    chk("br.pc_sel", 8'(pc_sel), 8'd2);
    chk("br.stall", 8'(stall), 8'd0);
    step();
    ex_branch_taken = 1'b0;
    drain();

    // Plain jump
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #2 chk("jmp.pc_sel", 8'(pc_sel), 8'd1);
    chk("jmp.flush", 8'(flush_ifid), 8'd1);
    chk("jmp.stall", 8'(stall), 8'd0);
    step();
    idle();
    #2 chk("jmp.after_pc_sel", 8'(pc_sel), 8'd0);
    chk("jmp.after_flush", 8'(flush_ifid), 8'd0);
    drain();

    // Jump whose source hazards: stall first, jump once clear
    drive(1, 1, 0, 0, 5, 1, 1, 0, 0);
    step();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1);
`ifdef HAZARD_FWD_EN
    #2 chk("jraw.stall", 8'(stall), 8'd1);
    chk("jraw.pc_sel", 8'(pc_sel), 8'd0);
    step();
`else
    for (int i = 0; i < 3; i++) begin
      #2 chk("jraw.stall", 8'(stall), 8'd1);
      chk("jraw.pc_sel", 8'(pc_sel), 8'd0);
      step();
    end
`endif
    #2 chk("jraw.jmp_pc_sel", 8'(pc_sel), 8'd1);
    chk("jraw.jmp_flush", 8'(flush_ifid), 8'd1);
    drain();

    // ADD r0=r0+r0 then a reader of r0: never hazards
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #2 chk("r0.stall", 8'(stall), 8'd0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
